// File: rtl/pdm_sequencer_if.sv
// Buffer-multiplexer bus between the sequencer and the PDM buffer mux.
// The sequencer drives the address; the mux returns the addressed word.
interface pdm_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] sample_select;
    logic [DATA_WIDTH-1:0] pdm_data_in;

    modport master (
        output sample_select,
        input  pdm_data_in
    );

    modport slave (
        input  sample_select,
        output pdm_data_in
    );
endinterface

// File: rtl/pdm_sequencer.sv
// PDM sequencer: steps the buffer mux address at a programmable rate
// and latches each selected word into glitch-free channel outputs.
module pdm_sequencer #(
    parameter int PDM_DATA_WIDTH          = 64,
    parameter int PDM_CHANNEL_WIDTH       = 16,
    parameter int PDM_BUFFER_ADRESS_WIDTH = 7,
    parameter int DIVIDER_WIDTH           = 32
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             enable,
    input  logic [DIVIDER_WIDTH-1:0]         samples_per_step,
    input  logic [PDM_BUFFER_ADRESS_WIDTH:0] num_steps,
    pdm_sequencer_if.master                  buf_if,
    output logic [PDM_DATA_WIDTH-1:0]        pdm_value_out,
    output logic                             pdm_valid,
    output logic                             step_strobe,
    output logic                             wrap_strobe,
    output logic [31:0]                      step_count
);
    localparam int AW     = PDM_BUFFER_ADRESS_WIDTH;
    localparam int CW     = PDM_CHANNEL_WIDTH;
    localparam int NUM_CH = PDM_DATA_WIDTH / PDM_CHANNEL_WIDTH;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             sel_q, sel_d;
    logic [DIVIDER_WIDTH-1:0]  div_q, div_d;
    logic [PDM_DATA_WIDTH-1:0] value_q, value_d;
    logic                      valid_q, valid_d;
    logic                      step_q, step_d;
    logic                      wrap_q, wrap_d;
    logic [31:0]               count_q, count_d;

    logic [DIVIDER_WIDTH-1:0]  sps_m1;
    logic [AW-1:0]             len_m1;

    // Last divider count and last address of the active sequence.
    always_comb begin
        sps_m1 = '0;
        if (samples_per_step != '0) begin
            sps_m1 = samples_per_step - 1'b1;
        end
        len_m1 = '0;
        if (num_steps >= DEPTH) begin
            len_m1 = '1;
        end else if (num_steps != '0) begin
            len_m1 = num_steps[AW-1:0] - 1'b1;
        end
    end

    // Next-state logic for the run/idle sequencer and its outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        div_d   = div_q;
        value_d = value_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                sel_d   = '0;
                div_d   = '0;
                value_d = '0;
                valid_d = 1'b0;
                count_d = '0;
                if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    div_d   = '0;
                    value_d = '0;
                    valid_d = 1'b0;
                    count_d = '0;
                end else begin
                    if (div_q == '0) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            value_d[k*CW +: CW] = buf_if.pdm_data_in[k*CW +: CW];
                        end
                        valid_d = 1'b1;
                        step_d  = 1'b1;
                        count_d = count_q + 32'd1;
                        wrap_d  = (sel_q == '0) && (count_q != '0);
                    end
                    if (div_q >= sps_m1) begin
                        div_d = '0;
                        sel_d = (sel_q >= len_m1) ? '0 : sel_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            div_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            value_q <= value_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
        end
    end

    assign buf_if.sample_select = sel_q;
    assign pdm_value_out        = value_q;
    assign pdm_valid            = valid_q;
    assign step_strobe          = step_q;
    assign wrap_strobe          = wrap_q;
    assign step_count           = count_q;
endmodule

// File: tb/tb_pdm_sequencer.sv
// Testbench for pdm_sequencer: scenario tasks plus a latch scoreboard
// fed with expected words and popped on every step strobe.
module tb_pdm_sequencer;
    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [31:0] samples_per_step;
    logic [7:0]  num_steps;
    logic [63:0] pdm_value_out;
    logic        pdm_valid;
    logic        step_strobe;
    logic        wrap_strobe;
    logic [31:0] step_count;

    logic [63:0] mem [128];

    typedef struct packed {
        logic [63:0] val;
        logic        wrap;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total;
    int   bad;
    logic sb_on;

    pdm_sequencer_if #(.DATA_WIDTH(64), .ADDR_WIDTH(7)) bif ();

    assign bif.pdm_data_in = mem[bif.sample_select];

    pdm_sequencer dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .enable           (enable),
        .samples_per_step (samples_per_step),
        .num_steps        (num_steps),
        .buf_if           (bif),
        .pdm_value_out    (pdm_value_out),
        .pdm_valid        (pdm_valid),
        .step_strobe      (step_strobe),
        .wrap_strobe      (wrap_strobe),
        .step_count       (step_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] word(int k);
        logic [63:0] w;
        for (int c = 0; c < 4; c++) begin
            w[16*c +: 16] = 16'(k * 32'h1111 + c);
        end
        return w;
    endfunction

    function automatic exp_t mk(int k, logic wr, int cnt);
        exp_t x;
        x.val  = word(k);
        x.wrap = wr;
        x.cnt  = 32'(cnt);
        return x;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: every step strobe must match the next expected latch.
    always @(negedge aclk) begin
        if (sb_on && step_strobe) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_latch got val=%h cnt=%0d", pdm_value_out, step_count);
            end else begin
                e = q.pop_front();
                if ({pdm_value_out, wrap_strobe, step_count, pdm_valid} !== {e, 1'b1}) begin
                    bad++;
                    $display("FAIL sb_latch got val=%h wrap=%b cnt=%0d valid=%b exp val=%h wrap=%b cnt=%0d valid=1",
                             pdm_value_out, wrap_strobe, step_count, pdm_valid, e.val, e.wrap, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        aresetn = 1'b0;
        enable = 1'b0;
        samples_per_step = 32'd4;
        num_steps = 8'd3;
        for (int k = 0; k < 128; k++) mem[k] = '1;
        #3;
        total++;
        if ({bif.sample_select, pdm_value_out, pdm_valid, step_strobe, wrap_strobe, step_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got sel=%0d val=%h valid=%b cnt=%0d exp all zero",
                     bif.sample_select, pdm_value_out, pdm_valid, step_count);
        end
        step();
        step();
        aresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({bif.sample_select, pdm_value_out, pdm_valid, step_strobe, wrap_strobe, step_count} !== '0) begin
                bad++;
                $display("FAIL idle_outputs cycle=%0d got sel=%0d val=%h valid=%b cnt=%0d exp all zero",
                         i, bif.sample_select, pdm_value_out, pdm_valid, step_count);
            end
        end
        for (int k = 0; k < 128; k++) mem[k] = word(k);
    endtask

    task automatic test_basic();
        logic [6:0] exp_sel;
        samples_per_step = 32'd4;
        num_steps = 8'd3;
        q.push_back(mk(0, 1'b0, 1));
        q.push_back(mk(1, 1'b0, 2));
        q.push_back(mk(2, 1'b0, 3));
        q.push_back(mk(0, 1'b1, 4));
        enable = 1'b1;
        step();
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) step();
            exp_sel = 7'((i / 4) % 3);
            total++;
            if (bif.sample_select !== exp_sel) begin
                bad++;
                $display("FAIL basic_sel t+%0d got %0d exp %0d", i, bif.sample_select, exp_sel);
            end
            total++;
            if (step_strobe !== (i % 4 == 1)) begin
                bad++;
                $display("FAIL basic_strobe t+%0d got %b exp %b", i, step_strobe, (i % 4 == 1));
            end
        end
        enable = 1'b0;
        step();
        total++;
        if ({bif.sample_select, pdm_value_out, pdm_valid, step_strobe, wrap_strobe, step_count} !== '0
            || q.size() != 0) begin
            bad++;
            $display("FAIL basic_stop got sel=%0d valid=%b cnt=%0d left=%0d exp zero",
                     bif.sample_select, pdm_valid, step_count, q.size());
        end
    endtask

    task automatic test_degenerate();
        samples_per_step = 32'd0;
        num_steps = 8'd0;
        for (int k = 0; k < 8; k++) q.push_back(mk(0, k > 0, k + 1));
        enable = 1'b1;
        step();
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) step();
            total++;
            if (bif.sample_select !== 7'd0 || step_strobe !== (i > 0)) begin
                bad++;
                $display("FAIL degen_zero t+%0d got sel=%0d strobe=%b exp sel=0 strobe=%b",
                         i, bif.sample_select, step_strobe, (i > 0));
            end
        end
        enable = 1'b0;
        step();
        total++;
        if (step_count !== 32'd0 || q.size() != 0) begin
            bad++;
            $display("FAIL degen_zero_stop got cnt=%0d left=%0d exp 0 0", step_count, q.size());
        end

        samples_per_step = 32'd1;
        num_steps = 8'd200;
        for (int k = 0; k < 130; k++) q.push_back(mk(k % 128, (k % 128 == 0) && (k > 0), k + 1));
        enable = 1'b1;
        step();
        for (int i = 0; i <= 130; i++) begin
            if (i > 0) step();
            total++;
            if (bif.sample_select !== 7'(i % 128)) begin
                bad++;
                $display("FAIL clamp_sel t+%0d got %0d exp %0d", i, bif.sample_select, i % 128);
            end
        end
        enable = 1'b0;
        step();
        total++;
        if (step_count !== 32'd0 || q.size() != 0) begin
            bad++;
            $display("FAIL clamp_stop got cnt=%0d left=%0d exp 0 0", step_count, q.size());
        end
    endtask

    task automatic test_live_reconfig();
        samples_per_step = 32'd100;
        num_steps = 8'd8;
        q.push_back(mk(0, 1'b0, 1));
        q.push_back(mk(1, 1'b0, 2));
        q.push_back(mk(2, 1'b0, 3));
        q.push_back(mk(3, 1'b0, 4));
        q.push_back(mk(4, 1'b0, 5));
        q.push_back(mk(5, 1'b0, 6));
        q.push_back(mk(0, 1'b1, 7));
        enable = 1'b1;
        step();
        for (int i = 1; i <= 102; i++) begin
            step();
            if (i == 50) begin
                total++;
                if (bif.sample_select !== 7'd0) begin
                    bad++;
                    $display("FAIL live_sps_before got %0d exp 0", bif.sample_select);
                end
                samples_per_step = 32'd10;
            end
            if (i == 51) begin
                total++;
                if (bif.sample_select !== 7'd1) begin
                    bad++;
                    $display("FAIL live_sps_after got %0d exp 1", bif.sample_select);
                end
            end
            if (i == 91) begin
                total++;
                if (bif.sample_select !== 7'd5) begin
                    bad++;
                    $display("FAIL live_len_at5 got %0d exp 5", bif.sample_select);
                end
                num_steps = 8'd2;
            end
            if (i == 100) begin
                total++;
                if (bif.sample_select !== 7'd5) begin
                    bad++;
                    $display("FAIL live_len_hold got %0d exp 5", bif.sample_select);
                end
            end
            if (i == 101) begin
                total++;
                if (bif.sample_select !== 7'd0) begin
                    bad++;
                    $display("FAIL live_len_wrap got %0d exp 0", bif.sample_select);
                end
            end
        end
        enable = 1'b0;
        step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL live_leftover got %0d exp 0", q.size());
        end
    endtask

    task automatic test_abort();
        samples_per_step = 32'd2;
        num_steps = 8'd8;
        q.push_back(mk(0, 1'b0, 1));
        q.push_back(mk(1, 1'b0, 2));
        q.push_back(mk(2, 1'b0, 3));
        enable = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) step();
        total++;
        if (bif.sample_select !== 7'd3) begin
            bad++;
            $display("FAIL abort_sel got %0d exp 3", bif.sample_select);
        end
        enable = 1'b0;
        step();
        total++;
        if ({bif.sample_select, pdm_value_out, pdm_valid, step_strobe, wrap_strobe, step_count} !== '0
            || q.size() != 0) begin
            bad++;
            $display("FAIL abort_clear got sel=%0d val=%h valid=%b cnt=%0d left=%0d exp zero",
                     bif.sample_select, pdm_value_out, pdm_valid, step_count, q.size());
        end
        q.push_back(mk(0, 1'b0, 1));
        enable = 1'b1;
        step();
        total++;
        if (bif.sample_select !== 7'd0 || pdm_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_entry got sel=%0d valid=%b exp 0 0", bif.sample_select, pdm_valid);
        end
        step();
        total++;
        if (step_count !== 32'd1 || pdm_value_out !== word(0)) begin
            bad++;
            $display("FAIL restart_first got cnt=%0d val=%h exp 1 %h", step_count, pdm_value_out, word(0));
        end
        enable = 1'b0;
        step();
        total++;
        if (step_count !== 32'd0 || q.size() != 0) begin
            bad++;
            $display("FAIL restart_stop got cnt=%0d left=%0d exp 0 0", step_count, q.size());
        end
    endtask

    task automatic test_async_reset();
        samples_per_step = 32'd3;
        num_steps = 8'd4;
        q.push_back(mk(0, 1'b0, 1));
        q.push_back(mk(1, 1'b0, 2));
        enable = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) step();
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if ({bif.sample_select, pdm_value_out, pdm_valid, step_strobe, wrap_strobe, step_count} !== '0) begin
            bad++;
            $display("FAIL async_clear got sel=%0d val=%h valid=%b cnt=%0d exp zero",
                     bif.sample_select, pdm_value_out, pdm_valid, step_count);
        end
        #3;
        aresetn = 1'b1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL async_leftover got %0d exp 0", q.size());
        end
        q.push_back(mk(0, 1'b0, 1));
        step();
        total++;
        if (bif.sample_select !== 7'd0 || pdm_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_restart got sel=%0d valid=%b exp 0 0", bif.sample_select, pdm_valid);
        end
        step();
        total++;
        if (step_count !== 32'd1) begin
            bad++;
            $display("FAIL async_first got cnt=%0d exp 1", step_count);
        end
        enable = 1'b0;
        step();
        total++;
        if (step_count !== 32'd0 || q.size() != 0) begin
            bad++;
            $display("FAIL async_stop got cnt=%0d left=%0d exp 0 0", step_count, q.size());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        sb_on = 1'b0;
        test_reset();
        sb_on = 1'b1;
        test_basic();
        test_degenerate();
        test_live_reconfig();
        test_abort();
        test_async_reset();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
